stack_engine: RTL and testbench

- 16-bit hardware stack sequencer for the CPU datapath.
- Accepts push/pop commands with a 16-bit word from the internal bus and performs them as two byte-wide transactions on the external memory port using a req/ack handshake.
- Maintains the stack pointer.
- Returns popped words onto the shared tri-state 16-bit internal bus under chip-select, the same way the datapath registers do.

---
 rtl/stack_engine.sv | 163 ++++++++++++++++
 tb/tb_stack_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_engine.sv
// 16-bit stack sequencer: pushes/pops words as two byte transactions on a req/ack
// memory port, maintains the stack pointer and returns popped words on a tri-state bus.
module stack_engine #(
  parameter logic [15:0] SP_RESET = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        sp_load,
  input  logic [15:0] bus_in,
  input  logic        cs_out,
  output logic [15:0] bus_out,
  output logic [15:0] sp,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH_HI = 3'd1,
    PUSH_LO = 3'd2,
    POP_LO  = 3'd3,
    POP_HI  = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_sp;
  logic [15:0] r_data;
  logic [15:0] r_word;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;

  state_t      w_state_nxt;
  logic [15:0] w_sp_nxt;
  logic [15:0] w_data_nxt;
  logic [15:0] w_word_nxt;
  logic        w_req_nxt;
  logic        w_we_nxt;
  logic [15:0] w_addr_nxt;
  logic [7:0]  w_wdata_nxt;
  logic        w_ack;

  // Handshake: a transaction completes on the rising edge where mem_req=1 and
  // mem_ack=1; the request fields stay frozen until then. mem_ack with mem_req=0
  // is ignored.
  assign w_ack = r_mem_req & mem_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sp        <= SP_RESET;
      r_data      <= 16'h0000;
      r_word      <= 16'h0000;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_sp        <= w_sp_nxt;
      r_data      <= w_data_nxt;
      r_word      <= w_word_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sp_nxt    = r_sp;
    w_data_nxt  = r_data;
    w_word_nxt  = r_word;
    w_req_nxt   = r_mem_req;
    w_we_nxt    = r_mem_we;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    case (r_state)
      IDLE: begin
        if (sp_load) begin
          w_sp_nxt = bus_in;
        end else if (push && !pop) begin
          w_word_nxt  = bus_in;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_sp - 16'd1;
          w_wdata_nxt = bus_in[15:8];
          w_state_nxt = PUSH_HI;
        end else if (pop && !push) begin
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = r_sp;
          w_state_nxt = POP_LO;
        end
      end
      PUSH_HI: begin
        if (w_ack) begin
          w_req_nxt   = 1'b0;
          w_addr_nxt  = r_sp - 16'd2;
          w_wdata_nxt = r_word[7:0];
          w_state_nxt = PUSH_LO;
        end
      end
      // Second-byte states enter with mem_req low: the first cycle is the gap.
      PUSH_LO: begin
        if (!r_mem_req) begin
          w_req_nxt = 1'b1;
        end else if (w_ack) begin
          w_req_nxt   = 1'b0;
          w_sp_nxt    = r_sp - 16'd2;
          w_state_nxt = FIN;
        end
      end
      POP_LO: begin
        if (w_ack) begin
          w_req_nxt       = 1'b0;
          w_data_nxt[7:0] = mem_rdata;
          w_addr_nxt      = r_sp + 16'd1;
          w_state_nxt     = POP_HI;
        end
      end
      POP_HI: begin
        if (!r_mem_req) begin
          w_req_nxt = 1'b1;
        end else if (w_ack) begin
          w_req_nxt        = 1'b0;
          w_data_nxt[15:8] = mem_rdata;
          w_sp_nxt         = r_sp + 16'd2;
          w_state_nxt      = FIN;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus_out     = cs_out ? r_data : 16'bz;
  assign sp          = r_sp;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == FIN);
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_we      = r_mem_we;
  assign mem_req     = r_mem_req;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stack_engine.sv
// Randomized bench for stack_engine: a byte-memory responder with variable ack delay,
// a word-level stack model and an expected-transaction queue.
module tb_stack_engine;

  localparam logic [15:0] SP_RESET = 16'hFFFF;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        push, pop, sp_load, cs_out;
  logic [15:0] bus_in;
  wire  [15:0] bus_w;
  logic [15:0] sp, mem_addr;
  logic        busy, done, mem_we, mem_req, mem_ack;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;
  logic        tb_drive;
  logic [15:0] tb_val;

  always #5 clk = ~clk;

  // Another bus driver, enabled only while the stack is not selected.
  assign bus_w = tb_drive ? tb_val : 16'bz;

  stack_engine #(.SP_RESET(SP_RESET)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .sp_load(sp_load),
    .bus_in(bus_in), .cs_out(cs_out), .bus_out(bus_w), .sp(sp), .busy(busy),
    .done(done), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [24:0] exp_q[$];            // {we, addr, byte}
  logic [15:0] m_sp;
  logic [15:0] m_data;
  logic [7:0]  m_mem[logic [15:0]];
  logic [7:0]  r_mem[logic [15:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Background contents of never-written memory, shared by responder and model.
  function automatic logic [7:0] fill(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] m_rd(input logic [15:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return fill(a);
  endfunction

  function automatic logic [7:0] r_rd(input logic [15:0] a);
    if (r_mem.exists(a)) return r_mem[a];
    return fill(a);
  endfunction

  // ---------------- memory responder ----------------
  int          ack_delay    = 0;
  int          acks_allowed = 1000000;
  bit          spurious_en  = 0;
  int          wait_cnt     = 0;
  int          low_run      = 0;
  bit          gap_check    = 0;
  logic [24:0] hold;
  logic [24:0] txn;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) mem_ack = 1'b0;
      if (!mem_req) begin
        wait_cnt = 0;
        low_run++;
        if (spurious_en && $urandom_range(0, 3) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = 8'($urandom);
        end
      end else begin
        if (wait_cnt == 0) begin
          if (gap_check) begin
            check("req_gap", low_run, 1);
            gap_check = 0;
          end
          hold = {mem_we, mem_addr, mem_wdata};
        end else begin
          check("req_hold", 32'({mem_we, mem_addr, mem_wdata}), 32'(hold));
        end
        low_run = 0;
        if (wait_cnt >= ack_delay && acks_allowed > 0) begin
          acks_allowed--;
          mem_ack = 1'b1;
          if (mem_we) begin
            r_mem[mem_addr] = mem_wdata;
            txn = {1'b1, mem_addr, mem_wdata};
          end else begin
            mem_rdata = r_rd(mem_addr);
            txn = {1'b0, mem_addr, mem_rdata};
          end
          check("txn_pending", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("txn", 32'(txn), 32'(exp_q.pop_front()));
          gap_check = (exp_q.size() % 2 == 1);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  int   done_cnt = 0;
  int   req_rise = 0;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_req && !prev_req) req_rise++;
    prev_req = mem_req;
  end

  // ---------------- driver tasks ----------------
  task automatic check_bus();
    tb_drive = 1'b0;
    cs_out   = 1'b1;
    #1;
    check("bus_drive", 32'(bus_w), 32'(m_data));
    cs_out   = 1'b0;
    tb_val   = 16'($urandom);
    tb_drive = 1'b1;
    #1;
    check("bus_release", 32'(bus_w), 32'(tb_val));
  endtask

  task automatic run_cmd(input logic p, input logic q, input logic l,
                         input logic [15:0] v, input int dly, input bit poke);
    int          dc0, rq0, n, starts;
    logic [15:0] a0, a1;
    logic [7:0]  lo, hi;
    ack_delay = dly;
    dc0 = done_cnt;
    rq0 = req_rise;
    starts = 0;
    @(negedge clk);
    push = p; pop = q; sp_load = l; bus_in = v;
    if (l) begin
      m_sp = v;
    end else if (p && !q) begin
      a0 = m_sp - 16'd1;
      a1 = m_sp - 16'd2;
      exp_q.push_back({1'b1, a0, v[15:8]});
      exp_q.push_back({1'b1, a1, v[7:0]});
      m_mem[a0] = v[15:8];
      m_mem[a1] = v[7:0];
      m_sp = a1;
      starts = 1;
    end else if (q && !p) begin
      a0 = m_sp;
      a1 = m_sp + 16'd1;
      lo = m_rd(a0);
      hi = m_rd(a1);
      exp_q.push_back({1'b0, a0, lo});
      exp_q.push_back({1'b0, a1, hi});
      m_data = {hi, lo};
      m_sp = m_sp + 16'd2;
      starts = 1;
    end
    @(negedge clk);
    push = 1'b0; pop = 1'b0; sp_load = 1'b0; bus_in = 16'($urandom);
    n = 1;
    if (starts == 1) begin
      check("busy_run", 32'(busy), 32'd1);
      if (poke) begin
        push = 1'b1; pop = 1'($urandom_range(0, 1)); sp_load = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
        push = 1'b0; pop = 1'b0; sp_load = 1'b0;
      end
      while (!done && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("latency", n, 4 + 2 * dly);
      @(negedge clk);
      check("busy_after", 32'(busy), 32'd0);
    end else begin
      check("busy_none", 32'(busy), 32'd0);
      @(negedge clk);
    end
    check("sp", 32'(sp), 32'(m_sp));
    check("done_cnt", done_cnt - dc0, starts);
    check("req_cnt", req_rise - rq0, 2 * starts);
    check("txn_left", exp_q.size(), 0);
    check_bus();
  endtask

  task automatic reset_mid_push();
    int          n, dc0;
    logic [15:0] a0;
    ack_delay    = 0;
    acks_allowed = 1;
    spurious_en  = 0;
    dc0 = done_cnt;
    @(negedge clk);
    push = 1'b1; bus_in = 16'hCAFE;
    a0 = m_sp - 16'd1;
    exp_q.push_back({1'b1, a0, 8'hCA});
    m_mem[a0] = 8'hCA;
    @(negedge clk);
    push = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("abort_waiting", 32'(mem_req & busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_req", 32'(mem_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sp", 32'(sp), 32'(SP_RESET));
    rst_n = 1'b1;
    acks_allowed = 1000000;
    m_sp   = SP_RESET;
    m_data = 16'h0000;
    repeat (3) @(negedge clk);
    check("abort_done", done_cnt - dc0, 0);
    check("abort_idle", 32'(mem_req | busy), 32'd0);
    check_bus();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; sp_load = 1'b0; bus_in = 16'h0000;
    cs_out = 1'b0; tb_drive = 1'b1; tb_val = 16'h5A5A;
    m_sp = SP_RESET; m_data = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_sp", 32'(sp), 32'(SP_RESET));
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_bus_z", 32'(bus_w), 32'h5A5A);
    check_bus();
    rst_n = 1'b1;

    run_cmd(1'b1, 1'b0, 1'b0, 16'hBEEF, 0, 1'b0);
    run_cmd(1'b0, 1'b1, 1'b0, 16'h0000, 3, 1'b0);
    check("pop_beef", 32'(m_data), 32'hBEEF);
    run_cmd(1'b0, 1'b0, 1'b1, 16'h0001, 0, 1'b0);
    run_cmd(1'b1, 1'b0, 1'b0, 16'h1234, 0, 1'b0);
    run_cmd(1'b0, 1'b1, 1'b0, 16'h0000, 1, 1'b0);
    run_cmd(1'b1, 1'b1, 1'b0, 16'h7777, 0, 1'b0);
    run_cmd(1'b1, 1'b0, 1'b0, 16'h1111, 1, 1'b1);
    run_cmd(1'b1, 1'b0, 1'b1, 16'h4321, 0, 1'b0);
    reset_mid_push();

    for (int i = 0; i < 60; i++) begin
      int          k, d;
      logic [15:0] v;
      bit          pk;
      k  = $urandom_range(0, 9);
      d  = $urandom_range(0, 3);
      v  = 16'($urandom);
      pk = 1'($urandom_range(0, 1));
      spurious_en = 1'($urandom_range(0, 1));
      case (k)
        0, 1, 2, 3: run_cmd(1'b1, 1'b0, 1'b0, v, d, pk);
        4, 5, 6:    run_cmd(1'b0, 1'b1, 1'b0, v, d, pk);
        7: begin
          if ($urandom_range(0, 1) == 1)
            v = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3))
                                            : 16'(32'hFFFC + $urandom_range(0, 3));
          run_cmd(1'b0, 1'b0, 1'b1, v, d, 1'b0);
        end
        8:       run_cmd(1'b1, 1'b1, 1'b0, v, d, 1'b0);
        default: run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, v, d, 1'b0);
      endcase
    end
    spurious_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
